// File: rtl/doorbell_scheduler.sv
//----------------------------------------------------------------------------
// doorbell_scheduler
//
// Turns host doorbell strobes into round-robin per-queue descriptor requests.
// A pending bitmap remembers which queues were rung; an in-flight bitmap makes
// sure each queue has at most one request outstanding. The provider->engine
// response handshake is snooped to retire in-flight requests. Queues that
// report a nonzero status (empty or error) stop being polled. Queues that
// delivered a descriptor (status 0) stay pending and are polled again.
//
// Optional build macro:
//   DOORBELL_SCHED_STATS_EN - adds the db_cnt / req_cnt / db_err_cnt
//                             saturating statistics counters and ports.
//
// Ports:
//   clk              in   single clock
//   rst              in   asynchronous, active-high reset
//   sched_enable     in   0 = load no new request (a held request completes)
//   doorbell_queue   in   queue number that was rung
//   doorbell_valid   in   single-cycle doorbell strobe, no back-pressure
//   desc_req_qnum    out  requested queue
//   desc_req_valid   out  request valid (held stable until desc_req_ready)
//   desc_req_ready   in   provider accepts the request
//   desc_rsp_qnum    in   snooped response queue
//   desc_rsp_status  in   snooped status, 0 = descriptor delivered
//   desc_rsp_valid   in   snooped response valid
//   desc_rsp_ready   in   snooped response ready
//   outstanding_cnt  out  requests accepted but not yet answered
//   sched_idle       out  registered: nothing pending, in flight or held
//   db_cnt           out  accepted doorbells             (stats build only)
//   req_cnt          out  completed request handshakes   (stats build only)
//   db_err_cnt       out  dropped doorbells + orphan rsp (stats build only)
//----------------------------------------------------------------------------
module doorbell_scheduler #(
    parameter int QUEUE_COUNT        = 32,
    parameter int QUEUE_NUMBER_WIDTH = 6,
    parameter int STATUS_WIDTH       = 4,
    parameter int MAX_OUTSTANDING    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sched_enable,
    input  logic [QUEUE_NUMBER_WIDTH-1:0] doorbell_queue,
    input  logic                          doorbell_valid,
    output logic [QUEUE_NUMBER_WIDTH-1:0] desc_req_qnum,
    output logic                          desc_req_valid,
    input  logic                          desc_req_ready,
    input  logic [QUEUE_NUMBER_WIDTH-1:0] desc_rsp_qnum,
    input  logic [STATUS_WIDTH-1:0]       desc_rsp_status,
    input  logic                          desc_rsp_valid,
    input  logic                          desc_rsp_ready,
    output logic [3:0]                    outstanding_cnt,
    output logic                          sched_idle
`ifdef DOORBELL_SCHED_STATS_EN
    ,
    output logic [31:0]                   db_cnt,
    output logic [31:0]                   req_cnt,
    output logic [31:0]                   db_err_cnt
`endif
);

    localparam int                     QW      = QUEUE_NUMBER_WIDTH;
    localparam logic [QW:0]            QCOUNT  = (QW+1)'(QUEUE_COUNT);
    localparam logic [3:0]             MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [QUEUE_COUNT-1:0] ONE     = QUEUE_COUNT'(1);

    // (base + off) mod QUEUE_COUNT; both operands are already below
    // QUEUE_COUNT, so a single conditional subtraction is enough.
    function automatic logic [QW-1:0] wrap_add(input logic [QW-1:0] base,
                                               input logic [QW-1:0] off);
        logic [QW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= QCOUNT) begin
            sum = sum - QCOUNT;
        end
        return sum[QW-1:0];
    endfunction

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    logic [QUEUE_COUNT-1:0] pending_q,  pending_d;
    logic [QUEUE_COUNT-1:0] inflight_q, inflight_d;
    logic [QW-1:0]          rr_ptr_q,   rr_ptr_d;
    logic                   req_valid_q, req_valid_d;
    logic [QW-1:0]          req_qnum_q,  req_qnum_d;
    logic [3:0]             outstanding_q, outstanding_d;
    logic                   idle_q, idle_d;

    //------------------------------------------------------------------------
    // Event decode
    //------------------------------------------------------------------------
    logic                   req_hs;
    logic                   rsp_hs;
    logic                   rsp_match;
    logic                   rsp_ok;
    logic                   rsp_error;
    logic                   db_in_range;
    logic                   db_accept;
    logic [QUEUE_COUNT-1:0] db_onehot;
    logic [QUEUE_COUNT-1:0] rsp_onehot;
    logic [QUEUE_COUNT-1:0] req_onehot;

    assign req_hs      = req_valid_q & desc_req_ready;
    assign rsp_hs      = desc_rsp_valid & desc_rsp_ready;

    // Shifting a one past the top of the vector yields zero, so
    // out-of-range queue numbers decode to an empty mask.
    assign db_onehot   = ONE << doorbell_queue;
    assign rsp_onehot  = ONE << desc_rsp_qnum;
    assign req_onehot  = ONE << req_qnum_q;

    assign db_in_range = {1'b0, doorbell_queue} < QCOUNT;
    assign db_accept   = doorbell_valid & db_in_range;

    // A response only counts if its queue really has a request in flight;
    // anything else (including responses after a reset) is an orphan.
    assign rsp_match   = |(inflight_q & rsp_onehot);
    assign rsp_ok      = rsp_hs & rsp_match;
    assign rsp_error   = desc_rsp_status != '0;

    //------------------------------------------------------------------------
    // Round-robin selection
    //------------------------------------------------------------------------
    logic [QUEUE_COUNT-1:0]   eligible;
    logic [2*QUEUE_COUNT-1:0] elig_dbl;
    logic [QUEUE_COUNT-1:0]   elig_rot;
    logic [QW-1:0]            next_after_req;
    logic [QW-1:0]            search_base;
    logic [QW-1:0]            sel_off;
    logic                     sel_found;
    logic [QW-1:0]            sel_qnum;
    logic                     req_load;

    // The queue handshaking this cycle is about to become in flight, so it
    // is masked out now to keep back-to-back issue from repeating it.
    assign eligible       = pending_q & ~inflight_q & ~(req_hs ? req_onehot : '0);

    assign next_after_req = wrap_add(req_qnum_q, QW'(1));
    // Search from where the pointer will be after this cycle's handshake.
    assign search_base    = req_hs ? next_after_req : rr_ptr_q;

    // Rotate so that bit 0 corresponds to search_base; the lowest set bit
    // of the rotated vector is then the next queue in round-robin order.
    assign elig_dbl       = {eligible, eligible};
    assign elig_rot       = QUEUE_COUNT'(elig_dbl >> search_base);

    // NOTE: every signal driven from always_comb gets a default assignment
    // at the top of the block so no path can leave it unassigned (latch).
    always_comb begin
        sel_found = 1'b0;
        sel_off   = '0;
        for (int i = QUEUE_COUNT - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                sel_found = 1'b1;
                sel_off   = QW'(i);
            end
        end
    end

    assign sel_qnum = wrap_add(search_base, sel_off);

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_hs && !rsp_ok) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!req_hs && rsp_ok) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // The cap is tested against the count after this cycle's handshake and
    // retirement, so the held request can never push it past the limit.
    assign req_load = (~req_valid_q | req_hs) & sched_enable & sel_found &
                      (outstanding_d < MAX_OUT);

    always_comb begin
        req_valid_d = req_valid_q;
        req_qnum_d  = req_qnum_q;
        if (req_load) begin
            req_valid_d = 1'b1;
            req_qnum_d  = sel_qnum;
        end else if (req_hs) begin
            req_valid_d = 1'b0;
        end
    end

    always_comb begin
        pending_d = pending_q;
        // Clear first, set second: a doorbell in the same cycle as an
        // empty/error response for the same queue keeps it pending.
        if (rsp_ok && rsp_error) begin
            pending_d = pending_d & ~rsp_onehot;
        end
        if (db_accept) begin
            pending_d = pending_d | db_onehot;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (rsp_ok) begin
            inflight_d = inflight_d & ~rsp_onehot;
        end
        if (req_hs) begin
            inflight_d = inflight_d | req_onehot;
        end
    end

    assign rr_ptr_d = req_hs ? next_after_req : rr_ptr_q;

    // Idle is judged on the current state and registered, so it reflects a
    // state change one cycle after it happens.
    assign idle_d   = (pending_q == '0) && (inflight_q == '0) && !req_valid_q;

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= '0;
            inflight_q    <= '0;
            rr_ptr_q      <= '0;
            req_valid_q   <= 1'b0;
            req_qnum_q    <= '0;
            outstanding_q <= '0;
            idle_q        <= 1'b1;
        end else begin
            pending_q     <= pending_d;
            inflight_q    <= inflight_d;
            rr_ptr_q      <= rr_ptr_d;
            req_valid_q   <= req_valid_d;
            req_qnum_q    <= req_qnum_d;
            outstanding_q <= outstanding_d;
            idle_q        <= idle_d;
        end
    end

    assign desc_req_valid  = req_valid_q;
    assign desc_req_qnum   = req_qnum_q;
    assign outstanding_cnt = outstanding_q;
    assign sched_idle      = idle_q;

`ifdef DOORBELL_SCHED_STATS_EN
    //------------------------------------------------------------------------
    // Statistics (saturating)
    //------------------------------------------------------------------------
    function automatic logic [31:0] sat_add(input logic [31:0] val,
                                            input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, val} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic        db_drop;
    logic        rsp_orphan;
    logic [1:0]  err_inc;
    logic [31:0] db_cnt_q, req_cnt_q, db_err_cnt_q;

    assign db_drop    = doorbell_valid & ~db_in_range;
    assign rsp_orphan = rsp_hs & ~rsp_match;
    // A dropped doorbell and an orphan response can land in the same cycle.
    assign err_inc    = {1'b0, db_drop} + {1'b0, rsp_orphan};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q     <= '0;
            req_cnt_q    <= '0;
            db_err_cnt_q <= '0;
        end else begin
            db_cnt_q     <= sat_add(db_cnt_q, {1'b0, db_accept});
            req_cnt_q    <= sat_add(req_cnt_q, {1'b0, req_hs});
            db_err_cnt_q <= sat_add(db_err_cnt_q, err_inc);
        end
    end

    assign db_cnt     = db_cnt_q;
    assign req_cnt    = req_cnt_q;
    assign db_err_cnt = db_err_cnt_q;
`endif

endmodule

// File: tb/tb_doorbell_scheduler.sv
//----------------------------------------------------------------------------
// Self-checking bench for doorbell_scheduler.
// A table of directed cycle vectors, a few hand-written multi-cycle
// sequences and a randomized phase are all compared cycle by cycle against
// a behavioural model built on plain arrays and modular arithmetic. A second
// instance with MAX_OUTSTANDING = 2 exercises the outstanding cap.
//----------------------------------------------------------------------------
module tb_doorbell_scheduler;

    localparam int QC   = 32;
    localparam int QW   = 6;
    localparam int SW   = 4;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sched_enable;
    logic [QW-1:0] doorbell_queue;
    logic          doorbell_valid;
    logic          desc_req_ready;
    logic [QW-1:0] desc_rsp_qnum;
    logic [SW-1:0] desc_rsp_status;
    logic          desc_rsp_valid;
    logic          desc_rsp_ready;

    logic [QW-1:0] desc_req_qnum;
    logic          desc_req_valid;
    logic [3:0]    outstanding_cnt;
    logic          sched_idle;

    logic [QW-1:0] qnum2;
    logic          valid2;
    logic [3:0]    cnt2;
    logic          idle2;
`ifdef DOORBELL_SCHED_STATS_EN
    logic [31:0]   db_cnt, req_cnt, db_err_cnt;
    logic [31:0]   db_cnt2, req_cnt2, db_err_cnt2;
`endif

    doorbell_scheduler #(
        .QUEUE_COUNT(QC), .QUEUE_NUMBER_WIDTH(QW),
        .STATUS_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .sched_enable(sched_enable),
        .doorbell_queue(doorbell_queue), .doorbell_valid(doorbell_valid),
        .desc_req_qnum(desc_req_qnum), .desc_req_valid(desc_req_valid),
        .desc_req_ready(desc_req_ready),
        .desc_rsp_qnum(desc_rsp_qnum), .desc_rsp_status(desc_rsp_status),
        .desc_rsp_valid(desc_rsp_valid), .desc_rsp_ready(desc_rsp_ready),
        .outstanding_cnt(outstanding_cnt), .sched_idle(sched_idle)
`ifdef DOORBELL_SCHED_STATS_EN
        , .db_cnt(db_cnt), .req_cnt(req_cnt), .db_err_cnt(db_err_cnt)
`endif
    );

    doorbell_scheduler #(
        .QUEUE_COUNT(QC), .QUEUE_NUMBER_WIDTH(QW),
        .STATUS_WIDTH(SW), .MAX_OUTSTANDING(2)
    ) dut_cap (
        .clk(clk), .rst(rst), .sched_enable(sched_enable),
        .doorbell_queue(doorbell_queue), .doorbell_valid(doorbell_valid),
        .desc_req_qnum(qnum2), .desc_req_valid(valid2),
        .desc_req_ready(desc_req_ready),
        .desc_rsp_qnum(desc_rsp_qnum), .desc_rsp_status(desc_rsp_status),
        .desc_rsp_valid(desc_rsp_valid), .desc_rsp_ready(desc_rsp_ready),
        .outstanding_cnt(cnt2), .sched_idle(idle2)
`ifdef DOORBELL_SCHED_STATS_EN
        , .db_cnt(db_cnt2), .req_cnt(req_cnt2), .db_err_cnt(db_err_cnt2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------------
    // Behavioural model
    //------------------------------------------------------------------------
    bit          m_pend[QC];
    bit          m_infl[QC];
    int          m_rr, m_cnt, m_q;
    bit          m_valid, m_idle;
    longint      m_db, m_req, m_err;

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < QC; i++) begin
            m_pend[i] = 1'b0;
            m_infl[i] = 1'b0;
        end
        m_rr = 0; m_cnt = 0; m_q = 0; m_valid = 1'b0; m_idle = 1'b1;
        m_db = 0; m_req = 0; m_err = 0;
    endtask

    task automatic inputs_quiet();
        doorbell_valid  = 1'b0;
        doorbell_queue  = '0;
        desc_rsp_valid  = 1'b0;
        desc_rsp_ready  = 1'b0;
        desc_rsp_qnum   = '0;
        desc_rsp_status = '0;
    endtask

    // Advance one clock: work out the model's next state from the inputs
    // present before the edge, then compare the DUT just after the edge.
    task automatic cyc();
        automatic bit hs       = m_valid && desc_req_ready;
        automatic bit rsp_fire = desc_rsp_valid && desc_rsp_ready;
        automatic int rq       = int'(desc_rsp_qnum);
        automatic bit rsp_ok   = rsp_fire && rq < QC && m_infl[rq];
        automatic bit rsp_bad  = desc_rsp_status != 0;
        automatic int dq       = int'(doorbell_queue);
        automatic bit db_ok    = doorbell_valid && dq < QC;
        automatic bit db_bad   = doorbell_valid && dq >= QC;
        automatic int cnt_next = m_cnt + int'(hs) - int'(rsp_ok);
        automatic int start    = hs ? (m_q + 1) % QC : m_rr;
        automatic int pick     = -1;
        automatic bit load;
        automatic bit any_state = m_valid;
        for (int k = 0; k < QC; k++) begin
            automatic int idx = (start + k) % QC;
            if (pick < 0 && m_pend[idx] && !m_infl[idx] && !(hs && idx == m_q))
                pick = idx;
            if (m_pend[k] || m_infl[k]) any_state = 1'b1;
        end
        load = (!m_valid || hs) && sched_enable && pick >= 0 && cnt_next < MAXO;

        @(posedge clk);
        #1;
        if (rsp_ok) begin
            m_infl[rq] = 1'b0;
            if (rsp_bad) m_pend[rq] = 1'b0;
        end
        if (db_ok) m_pend[dq] = 1'b1;
        if (hs) begin
            m_infl[m_q] = 1'b1;
            m_rr = (m_q + 1) % QC;
        end
        m_cnt  = cnt_next;
        m_idle = !any_state;
        if (load) begin
            m_valid = 1'b1;
            m_q     = pick;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        m_db  = sat32(m_db + longint'(db_ok));
        m_req = sat32(m_req + longint'(hs));
        m_err = sat32(m_err + longint'(db_bad) + longint'(rsp_fire && !rsp_ok));

        check("model_req_valid", desc_req_valid, m_valid);
        check("model_req_qnum", desc_req_qnum, m_q);
        check("model_outstanding", outstanding_cnt, m_cnt);
        check("model_idle", sched_idle, m_idle);
`ifdef DOORBELL_SCHED_STATS_EN
        check("model_db_cnt", db_cnt, m_db);
        check("model_req_cnt", req_cnt, m_req);
        check("model_db_err_cnt", db_err_cnt, m_err);
`endif
    endtask

    task automatic ring(input int q);
        doorbell_valid = 1'b1;
        doorbell_queue = QW'(q);
    endtask

    task automatic respond(input int q, input int status);
        desc_rsp_valid  = 1'b1;
        desc_rsp_ready  = 1'b1;
        desc_rsp_qnum   = QW'(q);
        desc_rsp_status = SW'(status);
    endtask

    //------------------------------------------------------------------------
    // Directed vector table
    //------------------------------------------------------------------------
    typedef struct {
        bit dbv; int dbq; bit rdy; bit en;
        bit rspv; int rspq; int rsps;
        bit ev; int eq; int ec; bit ei;
    } vec_t;

    vec_t tbl[19];

    int hs_count;

    initial begin
        //        dbv dbq rdy en rspv rspq rsps  ev eq ec ei
        tbl[0]  = '{0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1};
        tbl[1]  = '{1, 3, 1, 1, 0, 0, 0,  0, 0, 0, 1};  // ring q3
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 0,  1, 3, 0, 0};  // request 2 cycles later
        tbl[3]  = '{0, 0, 1, 1, 0, 0, 0,  0, 3, 1, 0};  // handshake -> 1 in flight
        tbl[4]  = '{0, 0, 1, 1, 1, 3, 1,  0, 3, 0, 0};  // empty response
        tbl[5]  = '{0, 0, 1, 1, 0, 0, 0,  0, 3, 0, 1};
        tbl[6]  = '{0, 0, 1, 1, 1, 2, 0,  0, 3, 0, 1};  // orphan response q2
        tbl[7]  = '{1, 40, 1, 1, 0, 0, 0, 0, 3, 0, 1};  // out-of-range doorbell
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 0,  0, 3, 0, 1};  // nothing issued
        tbl[9]  = '{1, 4, 1, 0, 0, 0, 0,  0, 3, 0, 1};  // ring q4, disabled
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0,  0, 3, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 0,  1, 4, 0, 0};  // enable -> load q4
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 4, 0, 0};  // held despite disable
        tbl[13] = '{0, 0, 1, 0, 0, 0, 0,  0, 4, 1, 0};  // held request completes
        tbl[14] = '{0, 0, 1, 1, 1, 4, 0,  0, 4, 0, 0};  // status 0: stays pending
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0,  1, 4, 0, 0};  // polled again
        tbl[16] = '{0, 0, 1, 1, 0, 0, 0,  0, 4, 1, 0};
        tbl[17] = '{0, 0, 1, 1, 1, 4, 2,  0, 4, 0, 0};  // error: stop polling
        tbl[18] = '{0, 0, 1, 1, 0, 0, 0,  0, 4, 0, 1};

        // Reset
        rst = 1'b1;
        sched_enable = 1'b1;
        desc_req_ready = 1'b0;
        inputs_quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_valid", desc_req_valid, 0);
        check("reset_req_qnum", desc_req_qnum, 0);
        check("reset_outstanding", outstanding_cnt, 0);
        check("reset_idle", sched_idle, 1);
        check("reset_cap_valid", valid2, 0);
        check("reset_cap_qnum", qnum2, 0);
        check("reset_cap_outstanding", cnt2, 0);
        check("reset_cap_idle", idle2, 1);
`ifdef DOORBELL_SCHED_STATS_EN
        check("reset_db_cnt", db_cnt, 0);
        check("reset_req_cnt", req_cnt, 0);
        check("reset_db_err_cnt", db_err_cnt, 0);
        check("reset_cap_stats", {db_cnt2, req_cnt2 | db_err_cnt2}, 0);
`endif
        rst = 1'b0;

        // Table
        for (int i = 0; i < 19; i++) begin
            inputs_quiet();
            doorbell_valid = tbl[i].dbv;
            doorbell_queue = QW'(tbl[i].dbq);
            desc_req_ready = tbl[i].rdy;
            sched_enable   = tbl[i].en;
            if (tbl[i].rspv) respond(tbl[i].rspq, tbl[i].rsps);
            cyc();
            check($sformatf("tbl%0d_valid", i), desc_req_valid, tbl[i].ev);
            check($sformatf("tbl%0d_qnum", i), desc_req_qnum, tbl[i].eq);
            check($sformatf("tbl%0d_outstanding", i), outstanding_cnt, tbl[i].ec);
            check($sformatf("tbl%0d_idle", i), sched_idle, tbl[i].ei);
        end
`ifdef DOORBELL_SCHED_STATS_EN
        check("tbl_db_cnt", db_cnt, 2);
        check("tbl_req_cnt", req_cnt, 3);
        check("tbl_db_err_cnt", db_err_cnt, 2);
`endif

        // Round robin from rr_ptr = 6: ring q5, serve it, retire it.
        inputs_quiet();
        sched_enable = 1'b1;
        desc_req_ready = 1'b1;
        ring(5); cyc();
        inputs_quiet(); cyc();
        check("rr_setup_q5", desc_req_qnum, 5);
        cyc();
        respond(5, 1); cyc();
        inputs_quiet();
        sched_enable = 1'b0;
        ring(1); cyc();
        ring(9); cyc();
        ring(5); cyc();
        inputs_quiet();
        sched_enable = 1'b1;
        cyc();
        check("rr_first_valid", desc_req_valid, 1);
        check("rr_first_q9", desc_req_qnum, 9);
        cyc();
        check("rr_second_valid", desc_req_valid, 1);
        check("rr_second_q1", desc_req_qnum, 1);
        cyc();
        check("rr_third_valid", desc_req_valid, 1);
        check("rr_third_q5", desc_req_qnum, 5);
        cyc();
        check("rr_done_valid", desc_req_valid, 0);
        check("rr_done_outstanding", outstanding_cnt, 3);
        respond(9, 1); cyc();
        respond(1, 1); cyc();
        respond(5, 1); cyc();
        inputs_quiet(); cyc();
        check("rr_retired_outstanding", outstanding_cnt, 0);

        // Doorbell and empty response for q7 in the same cycle.
        ring(7); cyc();
        inputs_quiet(); cyc();
        check("q7_first_req", desc_req_qnum, 7);
        cyc();
        check("q7_in_flight", outstanding_cnt, 1);
        ring(7); respond(7, 1); cyc();
        inputs_quiet();
        check("q7_not_yet_reissued", desc_req_valid, 0);
        cyc();
        check("q7_reissued_valid", desc_req_valid, 1);
        check("q7_reissued_qnum", desc_req_qnum, 7);
        cyc();
        respond(7, 1); cyc();
        inputs_quiet(); cyc();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            inputs_quiet();
            sched_enable   = ($urandom_range(0, 9) != 0);
            desc_req_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 3) ring($urandom_range(0, 39));
            if ($urandom_range(0, 9) < 4) begin
                automatic int st   = $urandom_range(0, QC - 1);
                automatic int pick = -1;
                for (int k = 0; k < QC; k++)
                    if (pick < 0 && m_infl[(st + k) % QC]) pick = (st + k) % QC;
                if (pick < 0 || $urandom_range(0, 9) < 2) pick = $urandom_range(0, 63);
                respond(pick, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 15) : 0);
                desc_rsp_ready = ($urandom_range(0, 9) < 8);
            end
            cyc();
        end

        // Asynchronous reset while a request is held with ready low.
        inputs_quiet();
        sched_enable = 1'b0;
        desc_req_ready = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        cyc();
        sched_enable = 1'b0;
        for (int q = 0; q < 4; q++) begin
            ring(q); cyc();
        end
        inputs_quiet();
        sched_enable = 1'b1;
        cyc();
        check("held_valid", desc_req_valid, 1);
        cyc();
        check("held_stable_qnum", desc_req_qnum, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_valid", desc_req_valid, 0);
        check("async_reset_cap_valid", valid2, 0);
        check("async_reset_outstanding", outstanding_cnt, 0);
        @(posedge clk);
        #1;
        check("reset_idle_next_cycle", sched_idle, 1);
        rst = 1'b0;
        model_reset();
        sched_enable = 1'b0;
        respond(0, 0); cyc();
        inputs_quiet();
        check("post_reset_orphan_outstanding", outstanding_cnt, 0);
        check("post_reset_orphan_valid", desc_req_valid, 0);

        // Outstanding cap on the MAX_OUTSTANDING = 2 instance.
        for (int q = 0; q < 4; q++) begin
            ring(q); cyc();
        end
        inputs_quiet();
        sched_enable = 1'b1;
        desc_req_ready = 1'b1;
        hs_count = 0;
        for (int n = 0; n < 8; n++) begin
            if (valid2 && desc_req_ready) hs_count++;
            cyc();
        end
        check("cap_handshakes", hs_count, 2);
        check("cap_valid_low", valid2, 0);
        check("cap_outstanding", cnt2, 2);
        hs_count = 0;
        respond(0, 0);
        for (int n = 0; n < 8; n++) begin
            if (valid2 && desc_req_ready) hs_count++;
            cyc();
            inputs_quiet();
        end
        check("cap_one_more_handshake", hs_count, 1);
        check("cap_valid_low_again", valid2, 0);
        check("cap_outstanding_again", cnt2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
